// File: rtl/add16u_mon_pkg.sv
// Shared types for the approximate-adder error monitor: FSM states, default operand width
// and the stats record layout (sized for the widest supported window).
package add16u_mon_pkg;

    localparam int ADD_WIDTH    = 16;
    localparam int MAX_WIN_LOG2 = 16;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        REPORT = 2'd2
    } mon_state_e;

    typedef struct packed {
        logic [ADD_WIDTH:0]              wce;
        logic [ADD_WIDTH+MAX_WIN_LOG2:0] sae;
        logic [MAX_WIN_LOG2:0]           errcnt;
    } stat_rec_t;

endpackage

// File: rtl/add16u_err_calc.sv
// First pipeline stage: exact sum of the operands and absolute distance of the approximate
// result from it, registered together with a valid bit.
module add16u_err_calc
    import add16u_mon_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush_i,
    input  logic           vld_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH:0] o_i,
    output logic           vld_o,
    output logic [WIDTH:0] diff_o
);

    function automatic logic [WIDTH:0] absdiff(input logic [WIDTH:0] x, input logic [WIDTH:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    logic [WIDTH:0] exact_p0;
    logic [WIDTH:0] diff_p0;
    logic           vld_p1_q;
    logic [WIDTH:0] diff_p1_q;

    assign exact_p0 = {1'b0, a_i} + {1'b0, b_i};
    assign diff_p0  = absdiff(o_i, exact_p0);

    // ---- p0 -> p1 ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_i & ~flush_i;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_i) begin
            diff_p1_q <= diff_p0;
        end
    end

    assign vld_o  = vld_p1_q;
    assign diff_o = diff_p1_q;

endmodule

// File: rtl/add16u_err_monitor.sv
// Accumulates WCE, sum of absolute error and error count over windows of 2**WIN_LOG2 samples
// and emits one registered stats record per window over a valid/ready handshake.
module add16u_err_monitor
    import add16u_mon_pkg::*;
#(
    parameter  int WIDTH    = ADD_WIDTH,
    parameter  int WIN_LOG2 = 10,
    localparam int ACC_W    = WIDTH + 1 + WIN_LOG2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [WIDTH:0]      in_o,
    output logic                stat_valid,
    input  logic                stat_ready,
    output logic [WIDTH:0]      stat_wce,
    output logic [ACC_W-1:0]    stat_sae,
    output logic [WIN_LOG2:0]   stat_errcnt
);

    localparam logic [WIN_LOG2:0] WIN_LAST = {1'b0, {WIN_LOG2{1'b1}}};
    localparam logic [WIN_LOG2:0] CNT_ONE  = {{WIN_LOG2{1'b0}}, 1'b1};

    mon_state_e          state_q, state_d;
    logic                rdy_en_q;
    logic                drain_q, drain_d;
    logic [WIN_LOG2:0]   cnt_q, cnt_d;
    logic [WIDTH:0]      wce_q, wce_d;
    logic [ACC_W-1:0]    sae_q, sae_d;
    logic [WIN_LOG2:0]   err_q, err_d;
    logic                snap;
    logic [WIDTH:0]      stat_wce_q;
    logic [ACC_W-1:0]    stat_sae_q;
    logic [WIN_LOG2:0]   stat_err_q;

    logic                accept;
    logic                vld_p1;
    logic [WIDTH:0]      diff_p1;

    // in_ready stays low until the first edge after reset release
    assign in_ready   = rdy_en_q && (state_q == ACCUM) && !clear;
    assign accept     = in_valid && in_ready;
    assign stat_valid = (state_q == REPORT);

    add16u_err_calc #(.WIDTH(WIDTH)) u_calc (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (clear),
        .vld_i   (accept),
        .a_i     (in_a),
        .b_i     (in_b),
        .o_i     (in_o),
        .vld_o   (vld_p1),
        .diff_o  (diff_p1)
    );

    // ---- p1 -> p2: accumulate, sequence windows ----
    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        cnt_d   = cnt_q;
        wce_d   = wce_q;
        sae_d   = sae_q;
        err_d   = err_q;
        snap    = 1'b0;

        if (vld_p1) begin
            if (diff_p1 > wce_q) begin
                wce_d = diff_p1;
            end
            sae_d = sae_q + ACC_W'(diff_p1);
            if (diff_p1 != '0) begin
                err_d = err_q + CNT_ONE;
            end
        end

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == WIN_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // second drain cycle: S1 is empty and the accumulators hold the final window
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = REPORT;
                    snap    = 1'b1;
                end
            end
            REPORT: begin
                if (stat_ready) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    wce_d   = '0;
                    sae_d   = '0;
                    err_d   = '0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase

        if (clear) begin
            state_d = ACCUM;
            drain_d = 1'b0;
            snap    = 1'b0;
            cnt_d   = '0;
            wce_d   = '0;
            sae_d   = '0;
            err_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            rdy_en_q   <= 1'b0;
            drain_q    <= 1'b0;
            cnt_q      <= '0;
            wce_q      <= '0;
            sae_q      <= '0;
            err_q      <= '0;
            stat_wce_q <= '0;
            stat_sae_q <= '0;
            stat_err_q <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            drain_q  <= drain_d;
            cnt_q    <= cnt_d;
            wce_q    <= wce_d;
            sae_q    <= sae_d;
            err_q    <= err_d;
            if (snap) begin
                stat_wce_q <= wce_q;
                stat_sae_q <= sae_q;
                stat_err_q <= err_q;
            end
        end
    end

    assign stat_wce    = stat_wce_q;
    assign stat_sae    = stat_sae_q;
    assign stat_errcnt = stat_err_q;

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Scoreboard bench: directed windows on a 4-sample monitor, random windows on a 1024-sample one.
module tb_add16u_err_monitor;
    import add16u_mon_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        clear2, in_valid2, in_ready2, stat_valid2, stat_ready2;
    logic [15:0] a2, b2;
    logic [16:0] o2, wce2;
    logic [18:0] sae2;
    logic [2:0]  err2;

    logic        clear10, in_valid10, in_ready10, stat_valid10, stat_ready10;
    logic [15:0] a10, b10;
    logic [16:0] o10, wce10;
    logic [26:0] sae10;
    logic [10:0] err10;

    add16u_err_monitor #(.WIDTH(16), .WIN_LOG2(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(a2), .in_b(b2), .in_o(o2), .stat_valid(stat_valid2), .stat_ready(stat_ready2),
        .stat_wce(wce2), .stat_sae(sae2), .stat_errcnt(err2)
    );

    add16u_err_monitor #(.WIDTH(16), .WIN_LOG2(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .clear(clear10), .in_valid(in_valid10), .in_ready(in_ready10),
        .in_a(a10), .in_b(b10), .in_o(o10), .stat_valid(stat_valid10), .stat_ready(stat_ready10),
        .stat_wce(wce10), .stat_sae(sae10), .stat_errcnt(err10)
    );

    int total = 0;
    int bad   = 0;
    int rec10 = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    stat_rec_t q2[$];
    stat_rec_t q10[$];
    stat_rec_t e2, e10;

    always @(negedge clk) begin
        if (rst_n && stat_valid2 && stat_ready2 && !clear2) begin
            if (q2.size() == 0) begin
                chk("rec2_unexpected", 64'd1, 64'd0);
            end else begin
                e2 = q2.pop_front();
                chk("rec2_wce", 64'(wce2), 64'(e2.wce));
                chk("rec2_sae", 64'(sae2), 64'(e2.sae));
                chk("rec2_errcnt", 64'(err2), 64'(e2.errcnt));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && stat_valid10 && stat_ready10 && !clear10) begin
            rec10++;
            if (q10.size() == 0) begin
                chk("rec10_unexpected", 64'd1, 64'd0);
            end else begin
                e10 = q10.pop_front();
                chk("rec10_wce", 64'(wce10), 64'(e10.wce));
                chk("rec10_sae", 64'(sae10), 64'(e10.sae));
                chk("rec10_errcnt", 64'(err10), 64'(e10.errcnt));
            end
        end
    end

    function automatic stat_rec_t mk(input int w, input int s, input int e);
        stat_rec_t r;
        r.wce    = 17'(w);
        r.sae    = 33'(s);
        r.errcnt = 17'(e);
        return r;
    endfunction

    // called #1 after a rising edge; returns #1 after the edge that accepted the sample
    task automatic send2(input logic [15:0] a, input logic [15:0] b, input logic [16:0] o);
        bit acc;
        acc = 1'b0;
        a2 = a; b2 = b; o2 = o; in_valid2 = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready2;
            @(posedge clk);
        end
        #1 in_valid2 = 1'b0;
        if (!acc) chk("send2_timeout", 64'd0, 64'd1);
    endtask

    // returns at the falling edge where stat_valid2 is first seen high
    task automatic wait_valid2(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = stat_valid2;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit        ok;
        int        stall;
        int        m_wce, m_sae, m_err;
        logic [16:0] ex, d;

        rst_n = 1'b0;
        clear2 = 1'b0; in_valid2 = 1'b0; stat_ready2 = 1'b1; a2 = '0; b2 = '0; o2 = '0;
        clear10 = 1'b0; in_valid10 = 1'b0; stat_ready10 = 1'b1; a10 = '0; b10 = '0; o10 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready2), 64'd0);
        chk("rst_stat_valid", 64'(stat_valid2), 64'd0);
        chk("rst_wce", 64'(wce2), 64'd0);
        chk("rst_sae", 64'(sae2), 64'd0);
        chk("rst_errcnt", 64'(err2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rdy_before_edge", 64'(in_ready2), 64'd0);
        @(posedge clk);
        #1 chk("rdy_after_edge", 64'(in_ready2), 64'd1);

        // mixed window, including max-error sample
        q2.push_back(mk(131071, 131076, 2));
        send2(16'd1, 16'd2, 17'd3);
        send2(16'd0, 16'd0, 17'h1FFFF);
        send2(16'hFFFF, 16'hFFFF, 17'h1FFFE);
        send2(16'd10, 16'd5, 17'd20);
        wait_valid2("t1_valid");
        @(posedge clk); #1;

        // all-exact window and in_ready gap
        q2.push_back(mk(0, 0, 0));
        repeat (4) send2(16'd5, 16'd7, 17'd12);
        chk("t2_rdy_drain", 64'(in_ready2), 64'd0);
        wait_valid2("t2_valid");
        chk("t2_rdy_report", 64'(in_ready2), 64'd0);
        @(posedge clk);
        #1 chk("t2_rdy_after_hs", 64'(in_ready2), 64'd1);

        // downstream back-pressure in REPORT
        stat_ready2 = 1'b0;
        q2.push_back(mk(7, 28, 4));
        repeat (4) send2(16'd3, 16'd4, 17'd0);
        wait_valid2("t3_valid");
        a2 = 16'd9; b2 = 16'd9; o2 = 17'd0; in_valid2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 64'(stat_valid2), 64'd1);
            chk("t3_hold_rdy", 64'(in_ready2), 64'd0);
            chk("t3_hold_wce", 64'(wce2), 64'd7);
            chk("t3_hold_sae", 64'(sae2), 64'd28);
            chk("t3_hold_err", 64'(err2), 64'd4);
        end
        @(posedge clk);
        #1 in_valid2 = 1'b0; stat_ready2 = 1'b1;
        @(posedge clk); #1;
        q2.push_back(mk(1, 4, 4));
        repeat (4) send2(16'd1, 16'd1, 17'd3);
        wait_valid2("t3b_valid");
        @(posedge clk); #1;

        // clear drops a partial window and the sample presented with it
        q2.push_back(mk(1, 4, 4));
        repeat (2) send2(16'd100, 16'd0, 17'd0);
        clear2 = 1'b1; a2 = 16'd7; b2 = 16'd0; o2 = 17'd900; in_valid2 = 1'b1;
        @(negedge clk);
        chk("t4_rdy_clear", 64'(in_ready2), 64'd0);
        @(posedge clk);
        #1 clear2 = 1'b0; in_valid2 = 1'b0;
        repeat (4) send2(16'd0, 16'd1, 17'd0);
        wait_valid2("t4_valid");
        @(posedge clk); #1;

        // reset while a record is pending
        stat_ready2 = 1'b0;
        repeat (4) send2(16'd2, 16'd2, 17'd5);
        wait_valid2("t5_valid");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid_rst", 64'(stat_valid2), 64'd0);
        chk("t5_wce_rst", 64'(wce2), 64'd0);
        chk("t5_sae_rst", 64'(sae2), 64'd0);
        chk("t5_err_rst", 64'(err2), 64'd0);
        chk("t5_rdy_rst", 64'(in_ready2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; stat_ready2 = 1'b1;
        @(posedge clk);
        #1 chk("t5_rdy_release", 64'(in_ready2), 64'd1);

        // random windows on the 1024-sample monitor
        for (int w = 0; w < 2; w++) begin
            ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                ok = in_ready10;
            end
            chk("rnd_ready_wait", 64'(ok), 64'd1);
            @(posedge clk); #1;
            stall = 0; m_wce = 0; m_sae = 0; m_err = 0;
            for (int i = 0; i < 1024; i++) begin
                a10 = 16'($urandom);
                b10 = 16'($urandom);
                ex  = {1'b0, a10} + {1'b0, b10};
                o10 = ($urandom_range(0, 1) == 1) ? ex : 17'($urandom);
                d   = (o10 >= ex) ? (o10 - ex) : (ex - o10);
                if (int'(d) > m_wce) m_wce = int'(d);
                m_sae += int'(d);
                if (d != 17'd0) m_err++;
                in_valid10 = 1'b1;
                @(negedge clk);
                if (!in_ready10) stall++;
                @(posedge clk); #1;
            end
            in_valid10 = 1'b0;
            q10.push_back(mk(m_wce, m_sae, m_err));
            chk("rnd_no_stall", 64'(stall), 64'd0);
        end
        for (int i = 0; i < 40 && q10.size() != 0; i++) @(negedge clk);
        chk("rnd_q_drained", 64'(q10.size()), 64'd0);
        chk("rnd_rec_count", 64'(rec10), 64'd2);
        chk("dir_q_drained", 64'(q2.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
